// File: rtl/alu_pkg.sv
// Shared opcode map and scheduler state encoding
// for the ALU issue scheduler.
package alu_pkg;

  localparam logic [4:0] OP_ADD = 5'h00;
  localparam logic [4:0] OP_SUB = 5'h01;
  localparam logic [4:0] OP_MUL = 5'h02;
  localparam logic [4:0] OP_DIV = 5'h03;
  localparam logic [4:0] OP_MAC = 5'h08;
  localparam logic [4:0] OP_ILL = 5'h0E;
  localparam logic [4:0] OP_BNE = 5'h10;

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    MAC_MUL,
    MAC_ADD,
    RESP
  } state_e;

  function automatic logic op_illegal(
    input logic [4:0] op
  );
    return (op == OP_ILL) || (op > OP_BNE);
  endfunction

endpackage

// File: rtl/alu_issue_sched_rr_arb2.sv
// Two-way round-robin grant: the pointed requester
// wins, the other only when the pointed one is idle.
module rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       ptr_i,
  output logic       gnt_o,
  output logic       id_o
);

  always_comb begin
    gnt_o = |valid_i;
    id_o  = valid_i[ptr_i] ? ptr_i : ~ptr_i;
  end

endmodule

// File: rtl/alu_issue_sched.sv
// Issue scheduler sharing one combinational ALU
// between two requesters; owns the MAC accumulator.
module alu_issue_sched
  import alu_pkg::*;
#(
  parameter int DATA_W  = 19,
  parameter int OP_W    = 5,
  parameter int DIV_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [OP_W-1:0]   req0_opcode,
  input  logic [DATA_W-1:0] req0_op1,
  input  logic [DATA_W-1:0] req0_op2,
  input  logic [OP_W-1:0]   req1_opcode,
  input  logic [DATA_W-1:0] req1_op1,
  input  logic [DATA_W-1:0] req1_op2,
  output logic [OP_W-1:0]   alu_opcode,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  input  logic              acc_clr
);

  localparam logic [3:0] DIV_CNT = 4'(DIV_LAT - 1);

  state_e            state_q, state_d;
  logic              rr_q, rr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [OP_W-1:0]   aopc_q, aopc_d;
  logic [DATA_W-1:0] aop1_q, aop1_d;
  logic [DATA_W-1:0] aop2_q, aop2_d;
  logic              rid_q, rid_d;
  logic [DATA_W-1:0] rdat_q, rdat_d;
  logic              rerr_q, rerr_d;

  logic              gnt, gid;
  logic [OP_W-1:0]   g_opc;
  logic [DATA_W-1:0] g_op1, g_op2;
  logic              g_ill, g_dz, g_mac;

  rr_arb2 u_arb (
    .valid_i (req_valid),
    .ptr_i   (rr_q),
    .gnt_o   (gnt),
    .id_o    (gid)
  );

  assign g_opc = gid ? req1_opcode : req0_opcode;
  assign g_op1 = gid ? req1_op1 : req0_op1;
  assign g_op2 = gid ? req1_op2 : req0_op2;
  assign g_ill = op_illegal(g_opc);
  assign g_dz  = (g_opc == OP_DIV) && (g_op2 == '0);
  assign g_mac = (g_opc == OP_MAC);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (gnt) begin
          if (g_ill || g_dz) state_d = RESP;
          else if (g_mac)    state_d = MAC_MUL;
          else               state_d = EXEC;
        end
      end
      EXEC:    if (cnt_q == '0) state_d = RESP;
      MAC_MUL: state_d = MAC_ADD;
      MAC_ADD: state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    aopc_d    = aopc_q;
    aop1_d    = aop1_q;
    aop2_d    = aop2_q;
    rid_d     = rid_q;
    rdat_d    = rdat_q;
    rerr_d    = rerr_q;
    // a MAC in flight owns the accumulator
    if (acc_clr && (state_q == IDLE || state_q == EXEC
                    || state_q == RESP))
      acc_d = '0;
    unique case (state_q)
      IDLE: begin
        if (gnt && rst_n) begin
          req_ready = gid ? 2'b10 : 2'b01;
          rr_d      = ~gid;
          rid_d     = gid;
          unique case (1'b1)
            g_ill: begin
              rdat_d = '0;
              rerr_d = 1'b1;
            end
            g_dz: begin
              rdat_d = '1;
              rerr_d = 1'b1;
            end
            g_mac: begin
              aopc_d = OP_MUL;
              aop1_d = g_op1;
              aop2_d = g_op2;
            end
            default: begin
              aopc_d = g_opc;
              aop1_d = g_op1;
              aop2_d = g_op2;
              cnt_d  = (g_opc == OP_DIV) ? DIV_CNT : '0;
            end
          endcase
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          rdat_d = alu_result;
          rerr_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      MAC_MUL: begin
        aopc_d = OP_ADD;
        aop1_d = alu_result;
        aop2_d = acc_q;
      end
      MAC_ADD: begin
        acc_d  = alu_result;
        rdat_d = alu_result;
        rerr_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_q   <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      aopc_q <= '0;
      aop1_q <= '0;
      aop2_q <= '0;
      rid_q  <= 1'b0;
      rdat_q <= '0;
      rerr_q <= 1'b0;
    end else begin
      rr_q   <= rr_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      aopc_q <= aopc_d;
      aop1_q <= aop1_d;
      aop2_q <= aop2_d;
      rid_q  <= rid_d;
      rdat_q <= rdat_d;
      rerr_q <= rerr_d;
    end
  end

  assign alu_opcode = aopc_q;
  assign alu_op1    = aop1_q;
  assign alu_op2    = aop2_q;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = rid_q;
  assign rsp_data   = rdat_q;
  assign rsp_err    = rerr_q;

endmodule

// File: tb/tb_alu_issue_sched.sv
// Bench for alu_issue_sched: behavioural ALU and
// scheduler reference model, directed plus random ops.
module tb_alu_issue_sched;

  localparam int DW  = 19;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [4:0]    req0_opcode, req1_opcode;
  logic [DW-1:0] req0_op1, req0_op2;
  logic [DW-1:0] req1_op1, req1_op2;
  logic [4:0]    alu_opcode;
  logic [DW-1:0] alu_op1, alu_op2, alu_result;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [DW-1:0] rsp_data;
  logic          acc_clr;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] m_acc;
  logic          m_ptr;

  always #5 clk = ~clk;

  alu_issue_sched #(.DATA_W(DW), .OP_W(5), .DIV_LAT(LAT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req0_opcode (req0_opcode),
    .req0_op1    (req0_op1),
    .req0_op2    (req0_op2),
    .req1_opcode (req1_opcode),
    .req1_op1    (req1_op1),
    .req1_op2    (req1_op2),
    .alu_opcode  (alu_opcode),
    .alu_op1     (alu_op1),
    .alu_op2     (alu_op2),
    .alu_result  (alu_result),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .acc_clr     (acc_clr)
  );

  function automatic logic [DW-1:0] alu_f(
    input logic [4:0] op,
    input logic [DW-1:0] a,
    input logic [DW-1:0] b
  );
    case (op)
      5'h00:   return a + b;
      5'h01:   return a - b;
      5'h02:   return a * b;
      5'h03:   return (b == 0) ? '1 : a / b;
      5'h04:   return a & b;
      5'h05:   return a | b;
      5'h06:   return a ^ b;
      5'h07:   return a << b[3:0];
      5'h08:   return 19'h5A5A5;
      default: return a ^ (b + DW'(op));
    endcase
  endfunction

  assign alu_result = alu_f(alu_opcode, alu_op1, alu_op2);

  task automatic chk_zero(input string nm);
    n_tests++;
    if (req_ready !== 2'b00 || rsp_valid !== 1'b0
        || rsp_id !== 1'b0 || rsp_data !== '0
        || rsp_err !== 1'b0 || alu_opcode !== '0
        || alu_op1 !== '0 || alu_op2 !== '0) begin
      n_fail++;
      $display("FAIL %s got rdy=%b v=%b id=%b d=%h e=%b op=%h a=%h b=%h exp all 0",
               nm, req_ready, rsp_valid, rsp_id, rsp_data,
               rsp_err, alu_opcode, alu_op1, alu_op2);
    end
  endtask

  task automatic drive(input int id, input logic [4:0] opc,
                       input logic [DW-1:0] a,
                       input logic [DW-1:0] b);
    if (id == 0) begin
      req0_opcode = opc; req0_op1 = a; req0_op2 = b;
    end else begin
      req1_opcode = opc; req1_op1 = a; req1_op2 = b;
    end
  endtask

  task automatic do_op(input int id, input logic [4:0] opc,
                       input logic [DW-1:0] a,
                       input logic [DW-1:0] b,
                       input bit clr_mac, input string nm);
    logic [DW-1:0] ed;
    logic          ee;
    int            el, n;
    bit            ok;
    logic [1:0]    eg;
    if (opc == 5'h0E || opc > 5'h10) begin
      ed = '0; ee = 1'b1; el = 1;
    end else if (opc == 5'h03 && b == 0) begin
      ed = '1; ee = 1'b1; el = 1;
    end else if (opc == 5'h08) begin
      ed = m_acc + a * b; ee = 1'b0; el = 3;
    end else begin
      ed = alu_f(opc, a, b); ee = 1'b0;
      el = (opc == 5'h03) ? 1 + LAT : 2;
    end
    eg = (id == 0) ? 2'b01 : 2'b10;
    rsp_ready = 1'b1;
    drive(id, opc, a, b);
    req_valid = eg;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready == 2'b00 && n < 20);
    n_tests++;
    if (req_ready !== eg) begin
      n_fail++;
      $display("FAIL %s_grant got %b exp %b", nm, req_ready, eg);
      req_valid = 2'b00;
      @(posedge clk); #1;
      return;
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    if (clr_mac) acc_clr = 1'b1;
    n = 0; ok = 1;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (rsp_valid) break;
      if (opc == 5'h03 && (alu_opcode !== 5'h03
          || alu_op1 !== a || alu_op2 !== b)) ok = 0;
      if (opc == 5'h08 && alu_opcode === 5'h08) ok = 0;
      if (clr_mac && n == 2) begin
        @(posedge clk); #1;
        acc_clr = 1'b0;
      end
    end
    acc_clr = 1'b0;
    n_tests++;
    if (n != el) begin
      n_fail++;
      $display("FAIL %s_lat got %0d exp %0d", nm, n, el);
    end
    n_tests++;
    if (rsp_data !== ed || rsp_err !== ee || rsp_id !== id[0]) begin
      n_fail++;
      $display("FAIL %s_rsp got d=%h e=%b id=%b exp d=%h e=%b id=%0d",
               nm, rsp_data, rsp_err, rsp_id, ed, ee, id);
    end
    if (opc == 5'h03 || opc == 5'h08) begin
      n_tests++;
      if (!ok) begin
        n_fail++;
        $display("FAIL %s_alu got unstable/illegal alu drive exp held op %h",
                 nm, opc);
      end
    end
    if (opc == 5'h08) m_acc = ed;
    m_ptr = ~id[0];
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b1;
    acc_clr = 1'b0;
    drive(0, 5'h0, '0, '0);
    drive(1, 5'h0, '0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    m_acc = '0; m_ptr = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    do_op(0, 5'h00, 19'd5, 19'd3, 0, "add");
    do_op(1, 5'h01, 19'd2, 19'd9, 0, "sub_wrap");
    do_op(0, 5'h02, 19'h7FFFF, 19'd3, 0, "mul_wrap");
    do_op(0, 5'h03, 19'd100, 19'd7, 0, "div");
    do_op(1, 5'h03, 19'd55, 19'd0, 0, "div0");
    do_op(0, 5'h0E, 19'd1, 19'd2, 0, "ill_0e");
    do_op(1, 5'h1F, 19'd1, 19'd2, 0, "ill_1f");
    do_op(0, 5'h10, 19'd4, 19'd4, 0, "bne");
  endtask

  task automatic test_mac();
    do_op(0, 5'h08, 19'd3, 19'd4, 0, "mac1");
    do_op(1, 5'h08, 19'd2, 19'd5, 1, "mac2_clr_ign");
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    m_acc = '0;
    do_op(0, 5'h08, 19'd6, 19'd7, 0, "mac3_after_clr");
  endtask

  task automatic test_backpressure();
    int n;
    rsp_ready = 1'b0;
    drive(0, 5'h00, 19'd9, 19'd10);
    req_valid = 2'b01;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready == 2'b00 && n < 20);
    @(posedge clk); #1;
    m_ptr = 1'b1;
    drive(0, 5'h00, 19'd1, 19'd1);
    drive(1, 5'h00, 19'd2, 19'd2);
    req_valid = 2'b11;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 20);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if (rsp_valid !== 1'b1 || rsp_data !== 19'd19
          || rsp_id !== 1'b0 || rsp_err !== 1'b0
          || req_ready !== 2'b00) begin
        n_fail++;
        $display("FAIL bp_hold%0d got v=%b d=%h id=%b e=%b rdy=%b exp 1/13/0/0/00",
                 i, rsp_valid, rsp_data, rsp_id, rsp_err, req_ready);
      end
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release got v=%b exp 0", rsp_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int n;
    drive(1, 5'h03, 19'd100, 19'd7);
    req_valid = 2'b10;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready == 2'b00 && n < 20);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_zero("reset_mid");
    @(negedge clk);
    rst_n = 1'b1;
    m_acc = '0; m_ptr = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid) n++;
    end
    n_tests++;
    if (n != 0) begin
      n_fail++;
      $display("FAIL reset_mid_norsp got %0d rsp cycles exp 0", n);
    end
    @(posedge clk); #1;
    do_op(0, 5'h08, 19'd1, 19'd2, 0, "mac_after_rst");
  endtask

  task automatic test_back_to_back();
    int            rem[2];
    int            got, cyc;
    bit            gf;
    logic          gid;
    logic [1:0]    eg;
    logic [DW:0]   q[$];
    logic [DW:0]   e;
    logic [DW-1:0] a0, b0, a1, b1;
    rem[0] = 4; rem[1] = 4;
    got = 0; cyc = 0; gf = 0; gid = 0;
    a0 = DW'($urandom); b0 = DW'($urandom);
    a1 = DW'($urandom); b1 = DW'($urandom);
    drive(0, 5'h00, a0, b0);
    drive(1, 5'h00, a1, b1);
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    while (got < 8 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (req_ready != 2'b00) begin
        if (req_valid == 2'b11) eg = m_ptr ? 2'b10 : 2'b01;
        else                    eg = req_valid;
        n_tests++;
        if (req_ready !== eg) begin
          n_fail++;
          $display("FAIL rr_grant got %b exp %b", req_ready, eg);
        end
        gid = req_ready[1];
        q.push_back(gid ? {1'b1, a1 + b1} : {1'b0, a0 + b0});
        m_ptr = ~gid;
        gf = 1;
      end
      if (rsp_valid) begin
        got++;
        e = (q.size() > 0) ? q.pop_front() : '1;
        n_tests++;
        if ({rsp_id, rsp_data} !== e) begin
          n_fail++;
          $display("FAIL rr_rsp got id=%b d=%h exp id=%b d=%h",
                   rsp_id, rsp_data, e[DW], e[DW-1:0]);
        end
      end
      @(posedge clk); #1;
      if (gf) begin
        rem[gid]--;
        if (rem[gid] == 0) req_valid[gid] = 1'b0;
        else if (gid) begin
          a1 = DW'($urandom); b1 = DW'($urandom);
          drive(1, 5'h00, a1, b1);
        end else begin
          a0 = DW'($urandom); b0 = DW'($urandom);
          drive(0, 5'h00, a0, b0);
        end
        gf = 0;
      end
    end
    req_valid = 2'b00;
    n_tests++;
    if (got != 8) begin
      n_fail++;
      $display("FAIL rr_timeout got %0d rsp exp 8", got);
    end
  endtask

  task automatic test_random();
    int            id;
    logic [4:0]    opc;
    logic [DW-1:0] a, b;
    for (int i = 0; i < 40; i++) begin
      id  = $urandom_range(0, 1);
      opc = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 2) == 0) opc = 5'h08;
      a = DW'($urandom);
      b = DW'($urandom);
      if ($urandom_range(0, 5) == 0) b = '0;
      if ($urandom_range(0, 7) == 0) begin
        acc_clr = 1'b1;
        @(posedge clk); #1;
        acc_clr = 1'b0;
        m_acc = '0;
      end
      do_op(id, opc, a, b,
            (opc == 5'h08) && ($urandom_range(0, 1) == 1), "rand");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mac();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
